// File: rtl/bcd_to_bin.sv
// 3-digit BCD to 10-bit binary converter using a reverse double-dabble sequencer; BCD_DIGIT_CHECK_EN adds an invalid-digit flag.
// Latency: done pulses in the 11th cycle after an accepted start. No backpressure: start is ignored while busy, and it is accepted in IDLE or DONE.
module bcd_to_bin (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [9:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_q, state_d;
  logic [11:0] work_q, work_d;
  logic [9:0]  res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bin_q, bin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [21:0] sh;
  logic [11:0] adj;
`ifdef BCD_DIGIT_CHECK_EN
  logic        inv_q, inv_d;
  logic        err_q, err_d;
  logic        bad_in;
`endif

  always_comb begin
    // One right shift of {work,result}, then the inverse of the add-3 correction.
    sh  = {1'b0, work_q, res_q[9:1]};
    adj = sh[21:10];
    for (int i = 0; i < 3; i++) begin
      if (sh[10+4*i +: 4] >= 4'd8) adj[4*i +: 4] = sh[10+4*i +: 4] - 4'd3;
    end

    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    bad_in  = (d2 > 4'd9) || (d1 > 4'd9) || (d0 > 4'd9);
    inv_d   = inv_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CONV;
          work_d  = {d2, d1, d0};
          res_d   = 10'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          inv_d   = bad_in;
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      CONV: begin
        work_d = adj;
        res_d  = sh[9:0];
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          bin_d   = inv_q ? 10'd0 : sh[9:0];
          err_d   = inv_q;
`else
          bin_d   = sh[9:0];
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      work_q  <= 12'd0;
      res_q   <= 10'd0;
      cnt_q   <= 4'd0;
      bin_q   <= 10'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
      inv_q   <= inv_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: latency, back-to-back sweep, start-while-busy, mid-conversion reset, digit check.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] d2, d1, d0;
  logic [9:0] bin;
  logic       busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_to_bin dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .d2     (d2),
    .d1     (d1),
    .d0     (d0),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single start pulse; inputs are scrambled after capture to prove they are ignored.
  task automatic run_conv(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [9:0] exp_bin, input logic exp_err);
    int busy_cnt;
    int done_seen;
    d2 = a; d1 = b; d0 = c; start = 1'b1;
    tick();
    start = 1'b0; d2 = ~a; d1 = ~b; d0 = ~c;
    busy_cnt  = 0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      busy_cnt  += int'(busy);
      done_seen += int'(done);
      tick();
    end
    check_eq("busy_cycles", busy_cnt, 10);
    check_eq("done_early", done_seen, 0);
    check_eq("done_11th", done, 1);
    check_eq("busy_in_done", busy, 0);
    check_eq("bin", bin, exp_bin);
    check_eq("err", err, exp_err);
  endtask

  initial begin
    int n;
    int pulses;
    resetn = 1'b0; start = 1'b0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    repeat (2) tick();
    check_eq("rst_bin", bin, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    resetn = 1'b1;
    tick();

    // Max value, then a few hand-picked vectors.
    run_conv(4'd9, 4'd9, 4'd9, 10'd999, 1'b0);
    tick();
    check_eq("done_one_cycle", done, 0);
    check_eq("bin_hold", bin, 999);
    run_conv(4'd0, 4'd0, 4'd0, 10'd0, 1'b0);
    run_conv(4'd5, 4'd1, 4'd2, 10'd512, 1'b0);
    run_conv(4'd1, 4'd0, 4'd0, 10'd100, 1'b0);
    run_conv(4'd8, 4'd0, 4'd8, 10'd808, 1'b0);
    tick();

    // Back-to-back sweep with start held: capture in DONE, done every 11 cycles.
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd0; start = 1'b1;
    for (n = 0; n < 1000; n++) begin
      tick();
      d2 = 4'((n + 1) / 100 % 10); d1 = 4'((n + 1) / 10 % 10); d0 = 4'((n + 1) % 10);
      repeat (9) tick();
      check_eq("sweep_no_done", done, 0);
      tick();
      check_eq("sweep_done", done, 1);
      check_eq("sweep_bin", bin, n);
    end
    start = 1'b0;
    tick();
    tick();
    check_eq("sweep_idle_busy", busy, 0);

    // Start pulsed in CONV cycle 4 must be ignored.
    d2 = 4'd2; d1 = 4'd5; d0 = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; d2 = 4'd0; d1 = 4'd0; d0 = 4'd1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check_eq("ign_no_done", done, 0);
    tick();
    check_eq("ign_done", done, 1);
    check_eq("ign_bin", bin, 255);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      pulses += int'(done) + int'(busy);
    end
    check_eq("ign_no_second", pulses, 0);
    check_eq("ign_bin_hold", bin, 255);

    // Reset in CONV cycle 5 clears everything immediately.
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_bin", bin, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_err", err, 0);
    tick();
    resetn = 1'b1;
    tick();
    check_eq("post_rst_idle", busy, 0);
    run_conv(4'd0, 4'd4, 4'd2, 10'd42, 1'b0);

    // Invalid digit: flagged with the check enabled, flag tied low otherwise.
    d2 = 4'd0; d1 = 4'd10; d0 = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check_eq("inv_done", done, 1);
`ifdef BCD_DIGIT_CHECK_EN
    check_eq("inv_err", err, 1);
    check_eq("inv_bin", bin, 0);
    tick();
    check_eq("inv_err_hold", err, 1);
`else
    check_eq("inv_err_tied", err, 0);
    tick();
`endif
    run_conv(4'd0, 4'd0, 4'd7, 10'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled on clk rising edge.
REQ-005 d2  input  4  BCD hundreds digit.
REQ-006 d1  input  4  BCD tens digit.
REQ-007 d0  input  4  BCD ones digit.
REQ-008 bin  output  10  binary result, 0..999.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when bin is valid.
REQ-011 err  output  1  invalid-digit flag, valid while done=1 and held afterwards.

Function
REQ-012 States SHALL be IDLE, CONV and DONE; reset state IDLE.
REQ-013 IDLE: start=1 SHALL capture {d2,d1,d0} into a 12-bit working register, clear the 10-bit result register and the 4-bit shift counter, and go to CONV.
REQ-014 CONV: each cycle SHALL shift {work,result} right by one bit (work LSB into result MSB), then subtract 3 from each work digit that is >=8; counter +1.
REQ-015 CONV SHALL last exactly 10 cycles; after the 10th shift the next state SHALL be DONE.
REQ-016 DONE SHALL last one cycle with done=1; bin SHALL be loaded from result on entry to DONE.
REQ-017 Latency: done SHALL be high in the 11th cycle after the edge that samples an accepted start.
REQ-018 busy SHALL be 1 in CONV only; done SHALL be 1 in DONE only.
REQ-019 start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back, no idle gap); done then still pulses for that cycle.
REQ-020 start in CONV SHALL be ignored; inputs d2..d0 SHALL be ignored except at the capture edge.
REQ-021 bin and err SHALL hold their last values until the next DONE entry.
REQ-022 For valid digits, bin SHALL equal 100*d2 + 10*d1 + d0, unsigned.

Reset
REQ-023 resetn=0 SHALL, asynchronously and at any time including mid-CONV, force IDLE, bin=0, busy=0, done=0, err=0, and clear the working register, result register and counter.
REQ-024 After resetn deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-025 Macro BCD_DIGIT_CHECK_EN SHALL control invalid-digit checking.
REQ-026 With BCD_DIGIT_CHECK_EN defined, any captured digit >9 SHALL set err=1 and force bin=0 at DONE entry.
REQ-027 With BCD_DIGIT_CHECK_EN defined, conversion timing SHALL be unchanged when err is set.
REQ-028 Without BCD_DIGIT_CHECK_EN, err SHALL be tied to 0.
REQ-029 Without BCD_DIGIT_CHECK_EN, bin for invalid digits SHALL be the raw algorithm output and SHALL NOT be checked.
REQ-030 Port list SHALL be identical in both builds.

Verification
REQ-031 d2,d1,d0=9,9,9, start for one cycle -> busy high 10 cycles; done=1 in 11th cycle; bin=999 (0x3E7); err=0.
REQ-032 Sweep 000..999 back-to-back, start held high -> each done shows bin=100*d2+10*d1+d0; done every 11 cycles.
REQ-033 Start 2,5,5; start pulsed again in CONV cycle 4 with inputs 0,0,1 -> single done; bin=255; no second conversion.
REQ-034 Start 1,2,3; resetn low in CONV cycle 5 -> all outputs 0 immediately; next start with 0,4,2 -> bin=42 after 11 cycles.
REQ-035 BCD_DIGIT_CHECK_EN defined; start with 0,10,3 -> done in 11th cycle; err=1; bin=0.
REQ-036 BCD_DIGIT_CHECK_EN defined; next start with 0,0,7 -> err returns to 0; bin=7.
